// File: rtl/rtc_pkg.sv
// rtc_pkg: shared FSM encodings, RTC register map constants and time-bus byte lanes.
package rtc_pkg;
  typedef logic [3:0] state_t;
  localparam state_t S_IDLE    = 4'd0;
  localparam state_t S_W_START = 4'd1;
  localparam state_t S_W_XFER  = 4'd2;
  localparam state_t S_W_END   = 4'd3;
  localparam state_t S_P_START = 4'd4;
  localparam state_t S_P_XFER  = 4'd5;
  localparam state_t S_P_END   = 4'd6;
  localparam state_t S_R_START = 4'd7;
  localparam state_t S_R_XFER  = 4'd8;
  localparam state_t S_R_END   = 4'd9;
  localparam logic [6:0] RTC_ADDR_DEFAULT = 7'h68;
  localparam logic [7:0] RTC_PTR_TIME = 8'h00;
  localparam int RTC_NREGS = 7;
  localparam int LANE_SEC = 0;
  localparam int LANE_MIN = 1;
  localparam int LANE_HOUR = 2;
  localparam int LANE_DAY = 3;
  localparam int LANE_DATE = 4;
  localparam int LANE_MONTH = 5;
  localparam int LANE_YEAR = 6;
  function automatic logic [7:0] time_byte(input logic [55:0] t, input logic [3:0] i);
    time_byte = 8'h00;
    for (int n = 0; n < RTC_NREGS; n++)
      if (i == 4'(n)) time_byte = t[n*8 +: 8];
  endfunction
endpackage

// File: rtl/rtc_poll_timer.sv
// rtc_poll_timer: free-running poll period counter; raises a sticky poll request on each wrap.
module rtc_poll_timer #(
  parameter int unsigned POLL_CYCLES = 25_000_000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic i_clr,
  output logic o_pend
);
  logic [31:0] r_cnt;
  logic        r_pend;
  logic        w_wrap;
  assign w_wrap = r_cnt == 32'(POLL_CYCLES - 1);
  assign o_pend = r_pend;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + 32'd1;
      r_pend <= w_wrap | (r_pend & ~i_clr);
    end
  end
endmodule

// File: rtl/rtc_i2c_scheduler.sv
// rtc_i2c_scheduler: sequences RTC time polls and host set-time writes over the I2C byte engine,
// with a per-transaction watchdog that returns to idle and flags err on a hung bus.
module rtc_i2c_scheduler import rtc_pkg::*; #(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned POLL_CYCLES    = CLK_HZ / 2,
  parameter int unsigned TIMEOUT_CYCLES = CLK_HZ / 50,
  parameter logic [6:0]  RTC_ADDR       = RTC_ADDR_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        set_req,
  input  logic [55:0] set_time,
  output logic        set_busy,
  output logic [55:0] time_out,
  output logic        time_valid,
  output logic        err,
  output logic        i2c_en,
  output logic        i2c_rw,
  output logic [6:0]  i2c_addr,
  output logic [7:0]  i2c_nbytes,
  output logic        i2c_valid,
  output logic [7:0]  i2c_data,
  input  logic        i2c_ready,
  input  logic        i2c_rvalid,
  input  logic [7:0]  i2c_rdata
);
  state_t      r_state;
  logic        r_rdy_d;
  logic [3:0]  r_k;
  logic [3:0]  r_j;
  logic [55:0] r_set_time;
  logic [55:0] r_shadow;
  logic [55:0] r_time;
  logic        r_set_pend;
  logic        r_tvalid;
  logic        r_err;
  logic        r_valid;
  logic [7:0]  r_data;
  logic [31:0] r_wd;
  logic        w_core_idle;
  logic        w_rdy_rise;
  logic        w_poll_pend;
  logic        w_poll_clr;
  logic        w_write_side;
  logic        w_read_side;
  logic        w_timeout;
  // ACK pulses are single-cycle highs; idle is ready held across two cycles
  assign w_core_idle  = i2c_ready & r_rdy_d;
  assign w_rdy_rise   = i2c_ready & ~r_rdy_d;
  assign w_write_side = (r_state == S_W_START) || (r_state == S_W_XFER) || (r_state == S_W_END);
  assign w_read_side  = (r_state == S_R_START) || (r_state == S_R_XFER);
  assign w_timeout    = (r_state != S_IDLE) && (r_wd >= 32'(TIMEOUT_CYCLES - 1));
  assign w_poll_clr   = (r_state == S_R_END) || (w_timeout && !w_write_side);
  assign set_busy     = r_set_pend;
  assign time_out     = r_time;
  assign time_valid   = r_tvalid;
  assign err          = r_err;
  assign i2c_en       = (r_state == S_W_START) || (r_state == S_P_START) || (r_state == S_R_START);
  assign i2c_rw       = w_read_side;
  assign i2c_addr     = RTC_ADDR;
  assign i2c_nbytes   = w_read_side ? 8'(RTC_NREGS) : 8'h00;
  assign i2c_valid    = r_valid;
  assign i2c_data     = r_data;
  rtc_poll_timer #(.POLL_CYCLES(POLL_CYCLES)) u_timer (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_clr   (w_poll_clr),
    .o_pend  (w_poll_pend)
  );
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rdy_d    <= 1'b0;
      r_k        <= '0;
      r_j        <= '0;
      r_set_time <= '0;
      r_shadow   <= '0;
      r_time     <= '0;
      r_set_pend <= 1'b0;
      r_tvalid   <= 1'b0;
      r_err      <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_wd       <= '0;
    end else begin
      r_rdy_d  <= i2c_ready;
      r_valid  <= 1'b0;
      r_tvalid <= 1'b0;
      r_wd     <= (r_state == S_IDLE) ? '0 : r_wd + 32'd1;
      if (set_req && !r_set_pend) begin
        r_set_time <= set_time;
        r_set_pend <= 1'b1;
      end
      if (w_timeout) begin
        r_err   <= 1'b1;
        r_state <= S_IDLE;
        if (w_write_side) r_set_pend <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE:
            if (w_core_idle && r_set_pend) r_state <= S_W_START;
            else if (w_core_idle && w_poll_pend) r_state <= S_P_START;
          S_W_START: begin
            r_k     <= '0;
            r_state <= S_W_XFER;
          end
          S_W_XFER:
            if (w_rdy_rise) begin
              if (r_k <= 4'd7) begin
                r_valid <= 1'b1;
                r_data  <= (r_k == 4'd0) ? RTC_PTR_TIME : time_byte(r_set_time, r_k - 4'd1);
                r_k     <= r_k + 4'd1;
              end else r_state <= S_W_END;
            end
          S_W_END:
            if (w_core_idle) begin
              r_state    <= S_IDLE;
              r_set_pend <= 1'b0;
              r_err      <= 1'b0;
            end
          S_P_START: begin
            r_k     <= '0;
            r_state <= S_P_XFER;
          end
          S_P_XFER:
            if (w_rdy_rise) begin
              if (r_k == 4'd0) begin
                r_valid <= 1'b1;
                r_data  <= RTC_PTR_TIME;
                r_k     <= 4'd1;
              end else r_state <= S_P_END;
            end
          S_P_END:
            if (w_core_idle) begin
              r_wd    <= '0;
              r_state <= S_R_START;
            end
          S_R_START: begin
            r_j     <= '0;
            r_state <= S_R_XFER;
          end
          S_R_XFER: begin
            if (i2c_rvalid && r_j < 4'(RTC_NREGS)) begin
              for (int n = 0; n < RTC_NREGS; n++)
                if (r_j == 4'(n)) r_shadow[n*8 +: 8] <= i2c_rdata;
              r_j <= r_j + 4'd1;
            end
            if (r_j == 4'(RTC_NREGS) && w_core_idle) r_state <= S_R_END;
          end
          S_R_END: begin
            r_time   <= r_shadow;
            r_tvalid <= 1'b1;
            r_err    <= 1'b0;
            r_state  <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
